// File: rtl/uart_rx_if.sv
// Receive-side output bundle of uart_rx: byte strobe, data and error pulses.
// The receiver drives it through the master modport; consumers use slave.
interface uart_rx_if;
    logic       arrived;
    logic [7:0] dataO;
    logic       frameErr;
    logic       parityErr;
    logic       busy;

    modport master (
        output arrived,
        output dataO,
        output frameErr,
        output parityErr,
        output busy
    );

    modport slave (
        input arrived,
        input dataO,
        input frameErr,
        input parityErr,
        input busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with start-bit validation and framing-error detection.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic      Clock,
    input  logic      Reset,
    input  logic      RX,
    uart_rx_if.master rx_if
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic [2:0]             idx_q;
    logic [7:0]             shift_q;
    logic [7:0]             data_q;
    logic                   arrived_q;
    logic                   ferr_q;
    logic                   rxs;

`ifdef UART_RX_PARITY_EN
    logic                   perr_q;
    logic                   pbad_q;
`endif

    assign rxs = sync_q[SYNC_STAGES-1];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= IDLE;
            sync_q    <= '1;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            arrived_q <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
            pbad_q    <= 1'b0;
`endif
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], RX};
            arrived_q <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    // mid-start-bit check rejects glitches
                    if (cnt_q == HALF_M1) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= rxs ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rxs;
                        idx_q          <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        pbad_q  <= rxs ^ (^shift_q);
                        state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q <= '0;
                        if (rxs) begin
`ifdef UART_RX_PARITY_EN
                            if (pbad_q) begin
                                perr_q <= 1'b1;
                            end else begin
                                data_q    <= shift_q;
                                arrived_q <= 1'b1;
                            end
`else
                            data_q    <= shift_q;
                            arrived_q <= 1'b1;
`endif
                            state_q <= IDLE;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= BRK;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                BRK: begin
                    // a held-low line must not look like a new start
                    if (rxs) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_if.arrived  = arrived_q;
    assign rx_if.dataO    = data_q;
    assign rx_if.frameErr = ferr_q;
    assign rx_if.busy     = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign rx_if.parityErr = perr_q;
`else
    assign rx_if.parityErr = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver stage that consumes the TX line driven by the transmitter inside the alarm system. Produces bytes via the `arrived`/`dataO` interface.
- Deserialises 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit. Includes start-bit validation and framing-error detection.
- Sits between the serial pin and the command decoder. A bench loopback connects TX to RX.

Parameters:
- CLKS_PER_BIT, 16, Clock cycles per bit period. Must be even and >= 4.
- SYNC_STAGES, 2, number of flops in the RX input synchroniser (>= 2).

Ports:
- Clock  in  1  Single system clock; all logic on its rising edge.
- Reset  in  1  Synchronous, active-high reset.
- RX  in  1  Asynchronous serial input; idles high.
- arrived  out  1  One-cycle pulse; `dataO` holds a new valid byte.
- dataO  out  8  Last correctly received byte; stable between `arrived` pulses.
- frameErr  out  1  One-cycle pulse; the stop bit was sampled low.
- parityErr  out  1  One-cycle pulse on a parity mismatch (see Optional Feature).
- busy  out  1  High whenever the FSM is not in IDLE.

Behaviour:
- Reset (Clock edge with Reset=1):
  - State=IDLE.
  - Synchroniser flops preset to 1.
  - Bit counter and cycle counter cleared to 0.
  - Outputs: `dataO`=8'h00, `arrived`=0, `frameErr`=0, `parityErr`=0, `busy`=0.
  - Reset mid-frame aborts the frame. No pulse is emitted. The partial byte is discarded.
- Synchroniser: `rxs` = RX delayed SYNC_STAGES cycles. All decisions below use `rxs`.
- IDLE:
  - When `rxs`==0, go to START and clear the cycle counter.
- START:
  - Count to CLKS_PER_BIT/2-1, then sample `rxs`.
  - Sample 1: false start; return to IDLE with no output pulse.
  - Sample 0: go to DATA; clear counter and bit index.
- DATA:
  - Count to CLKS_PER_BIT-1, then sample `rxs` into shift bit [index]. LSB is received first.
  - After index 7 is sampled, go to STOP (or PARITY if enabled).
- STOP:
  - Count to CLKS_PER_BIT-1, then sample `rxs`.
  - Sample 1: `dataO` <= shift register; `arrived`=1 for exactly one cycle, on the cycle after the sample; return to IDLE.
  - Sample 0: `frameErr`=1 for one cycle; `dataO` is unchanged; go to BREAK.
- BREAK:
  - Wait until `rxs`==1, then go to IDLE.
  - A low line is never treated as a new start while in BREAK.
- Latency, with T0 = the first Clock edge at which the RX pin is registered low:
  - Stop sample occurs at T0 + SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT.
  - `arrived` is high on the following cycle. With defaults that is T0+155.
- Back-to-back frames:
  - FSM is in IDLE one cycle after the stop sample.
  - A start edge arriving half a bit after the stop sample (zero idle gap at the transmitter) is accepted.
- Output exclusivity: `arrived`, `frameErr` and `parityErr` are never high in the same cycle.
- Timing tolerance: the counters free-run per bit with no resynchronisation inside a frame. Tolerance is ±4% transmitter rate mismatch at CLKS_PER_BIT=16.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP and samples one even-parity bit mid-bit.
  - On a mismatch, the frame still proceeds to STOP.
  - Valid stop bit: `parityErr` pulses instead of `arrived`, and `dataO` is unchanged.
  - Stop bit low: `frameErr` takes precedence.
  - Frame length is 11 bits; latency grows by CLKS_PER_BIT.
- Undefined: no PARITY state; `parityErr` is tied to 0.

Test Plan:
- Send 8'h42 at CLKS_PER_BIT=16 -> single `arrived` pulse at T0+155 with `dataO`=8'h42; `frameErr`=0 throughout.
- Back-to-back 8'hAA then 8'h45 with zero idle gap -> two `arrived` pulses 160 cycles apart carrying 8'hAA then 8'h45.
- RX low glitch of 4 cycles, then high -> `busy` pulses; no `arrived` and no `frameErr`; FSM returns to IDLE; next frame 8'h72 is received correctly.
- Frame 8'hF3 with stop bit forced 0 and line held low 40 cycles -> `frameErr` pulses once; `dataO` retains 8'h72; no start is detected until the line goes high; then 8'h52 is received.
- Reset asserted for 1 cycle during data bit 4 of 8'hCE -> no pulse; `busy`=0 the next cycle; the following 8'h77 is received.
- With UART_RX_PARITY_EN: 8'h0A with correct even parity -> `arrived`; 8'h92 with flipped parity -> `parityErr` pulse; `dataO` stays 8'h0A.
